game_fsm: RTL and testbench
===========================

# game_fsm

Top-level game-flow controller between the input debouncers and the play-field blocks (falling_item, stack, counter). It turns debounced button levels into edges and sequences the game through IDLE, PLAY, PAUSE and OVER. It drives the single `stop` freeze signal and tracks remaining lives from bomb collisions. It also latches a session high score for the 7-segment display.

## Interface
Parameters:
- `LIVES`, 3: lives at game start (1–3).
- `BOMB_COLOR`, 2'b11: `fall_clr` value that costs a life on collision.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset (debounced start button).
- `pause`  in  1  debounced pause level.
- `left`  in  1  debounced left level.
- `right`  in  1  debounced right level.
- `one_hz`  in  1  1 Hz square wave from clk_divider, sampled in the `clk` domain.
- `end_game`  in  1  timer expiry level from counter.
- `collision`  in  1  single-cycle catch pulse from stack.
- `fall_clr`  in  2  colour of the item being caught, valid with `collision`.
- `score`  in  7  current score from the score block.
- `stop`  out  1  freeze for falling_item, stack and counter.
- `state`  out  2  IDLE=0, PLAY=1, PAUSE=2, OVER=3.
- `lives`  out  2  remaining lives.
- `high_score`  out  7  best final score this session.
- `blink`  out  1  display blink phase.
- `game_over`  out  1  high while in OVER.

## Operation
- Edge detection:
  - One previous-value register each for `pause`, `left`, `right` and `one_hz`.
  - Rising edge = `in & ~prev`.
  - `rst` sets every prev register to 1, so a button held through reset produces no edge.
- State transitions (exactly one per cycle):
  - IDLE: a `left` or `right` edge goes to PLAY. Lives load `LIVES`.
  - PLAY:
    - OVER if `end_game` is high, or if a bomb collision takes `lives` from 1 to 0.
    - Otherwise a `pause` edge goes to PAUSE.
    - OVER has priority over PAUSE.
  - PAUSE: `end_game` goes to OVER (priority). Otherwise a `pause` edge goes to PLAY.
  - OVER: terminal; only `rst` leaves it.
- Lives:
  - In PLAY, `collision` with `fall_clr == BOMB_COLOR` decrements `lives`, saturating at 0.
  - Collisions in any other state are ignored.
- `stop` = (next state != PLAY), registered.
- `game_over` = (state == OVER), registered.
- `blink`:
  - Toggles on every `one_hz` edge while in PAUSE or OVER.
  - Forced to 0 in IDLE and PLAY.
- `high_score`:
  - On the cycle that enters OVER, it loads `max(high_score, score)`. Unsigned 7-bit compare.
  - Not affected by `rst`; it initialises to 0 at configuration, so it persists across restarts.

## Timing
- Values after `rst`:
  - `state` = IDLE, `stop` = 1, `lives` = `LIVES`, `blink` = 0, `game_over` = 0.
  - `high_score` is unchanged by `rst`.
- Latency: an input edge presented in cycle N changes `state`, `stop`, `game_over` and `lives` at clock edge N+1 (prev-register compare is combinational).
- A bomb collision that empties `lives` updates `lives` to 0 and `state` to OVER on the same edge.
- `high_score` updates on that same edge, using the `score` value sampled in cycle N.
- `rst` wins over every other input in every state, including mid-pause and in OVER.
- `pause` and `left`/`right` edges together in IDLE: go to PLAY; the pause edge is discarded.

## Configuration
- `GAME_FSM_LIVES_EN` defined:
  - The lives logic is compiled in.
  - Bomb collisions decrement `lives`, and `lives` reaching 0 ends the game.
- `GAME_FSM_LIVES_EN` undefined:
  - The lives logic is not compiled in.
  - `lives` is the constant `LIVES`, collisions never change state, and only `end_game` reaches OVER.

## Test plan
- Start from IDLE:
  - Assert `rst` for 1 cycle: `state` = 0, `stop` = 1.
  - Pulse `right` high for 3 cycles: `state` = 1 and `stop` = 0 one cycle after the rise, with one transition only.
- Pause toggle:
  - From PLAY, raise `pause` and hold 10 cycles: `state` = 2 and `stop` = 1 after 1 cycle, with no re-toggle.
  - Drop then raise `pause` again: `state` = 1.
- Bombs (macro defined, `LIVES` = 3):
  - Three `collision` pulses with `fall_clr` = 3: `lives` goes 2, 1, 0, and `state` = 3 on the third.
  - A pulse with `fall_clr` = 1 leaves `lives` unchanged.
- Priority: in PLAY, assert `end_game` in the same cycle as a `pause` edge: `state` = 3, `game_over` = 1, `stop` = 1.
- High score:
  - First game ends with `score` = 42: `high_score` = 42.
  - After `rst`, a second game ends with `score` = 17: `high_score` stays 42.
  - Without the macro, 5 bomb collisions leave `lives` = 3 and `state` = 1.
- Blink:
  - In PAUSE, 4 `one_hz` rising edges: `blink` toggles 4 times.
  - Return to PLAY: `blink` = 0.

Source files
------------

// File: rtl/game_fsm_if.sv
// rtl/game_fsm_if.sv - game_fsm signal bundle: debounced inputs and play-field
// status toward the controller, freeze/state/lives/score display outputs back.
interface game_fsm_if;
  logic       pause;
  logic       left;
  logic       right;
  logic       one_hz;
  logic       end_game;
  logic       collision;
  logic [1:0] fall_clr;
  logic [6:0] score;
  logic       stop;
  logic [1:0] state;
  logic [1:0] lives;
  logic [6:0] high_score;
  logic       blink;
  logic       game_over;

  modport slave (
    input  pause, left, right, one_hz, end_game, collision, fall_clr, score,
    output stop, state, lives, high_score, blink, game_over
  );

  modport master (
    output pause, left, right, one_hz, end_game, collision, fall_clr, score,
    input  stop, state, lives, high_score, blink, game_over
  );
endinterface

// File: rtl/game_fsm.sv
// rtl/game_fsm.sv - game flow controller IDLE/PLAY/PAUSE/OVER with lives and high score.
// Optional bomb/lives logic is compiled in with GAME_FSM_LIVES_EN.
module game_fsm #(
  parameter int         LIVES      = 3,
  parameter logic [1:0] BOMB_COLOR = 2'b11
) (
  input  logic         i_clk,
  input  logic         i_rst,
  game_fsm_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_pause_prev;
  logic       r_left_prev;
  logic       r_right_prev;
  logic       r_one_hz_prev;
  logic       r_stop;
  logic       r_game_over;
  logic       r_blink;
  // No reset on purpose: the best score must survive restarts.
  logic [6:0] r_high_score = 7'd0;
  logic       w_pause_edge;
  logic       w_left_edge;
  logic       w_right_edge;
  logic       w_one_hz_edge;
  logic       w_last_life;

  assign w_pause_edge  = bus.pause  & ~r_pause_prev;
  assign w_left_edge   = bus.left   & ~r_left_prev;
  assign w_right_edge  = bus.right  & ~r_right_prev;
  assign w_one_hz_edge = bus.one_hz & ~r_one_hz_prev;

`ifdef GAME_FSM_LIVES_EN
  logic [1:0] r_lives;
  logic       w_bomb;

  assign w_bomb      = bus.collision && (bus.fall_clr == BOMB_COLOR) && (r_state == PLAY);
  assign w_last_life = w_bomb && (r_lives == 2'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lives <= 2'(LIVES);
    end else if (r_state == IDLE && w_next == PLAY) begin
      r_lives <= 2'(LIVES);
    end else if (w_bomb && r_lives != 2'd0) begin
      r_lives <= r_lives - 2'd1;
    end
  end

  assign bus.lives = r_lives;
`else
  logic w_unused;

  assign w_last_life = 1'b0;
  assign w_unused    = ^{bus.collision, bus.fall_clr, BOMB_COLOR};
  assign bus.lives   = 2'(LIVES);
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        // A simultaneous pause edge is simply dropped here.
        if (w_left_edge || w_right_edge) w_next = PLAY;
      end
      PLAY: begin
        if (bus.end_game || w_last_life) w_next = OVER;
        else if (w_pause_edge)           w_next = PAUSE;
      end
      PAUSE: begin
        if (bus.end_game)      w_next = OVER;
        else if (w_pause_edge) w_next = PLAY;
      end
      default: w_next = OVER;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Prevs at 1 so a button held through reset yields no edge.
      r_pause_prev  <= 1'b1;
      r_left_prev   <= 1'b1;
      r_right_prev  <= 1'b1;
      r_one_hz_prev <= 1'b1;
      r_state       <= IDLE;
      r_stop        <= 1'b1;
      r_game_over   <= 1'b0;
      r_blink       <= 1'b0;
    end else begin
      r_pause_prev  <= bus.pause;
      r_left_prev   <= bus.left;
      r_right_prev  <= bus.right;
      r_one_hz_prev <= bus.one_hz;
      r_state       <= w_next;
      r_stop        <= (w_next != PLAY);
      r_game_over   <= (w_next == OVER);
      if (w_next == IDLE || w_next == PLAY) begin
        r_blink <= 1'b0;
      end else if ((r_state == PAUSE || r_state == OVER) && w_one_hz_edge) begin
        r_blink <= ~r_blink;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_next == OVER && r_state != OVER && bus.score > r_high_score) begin
      r_high_score <= bus.score;
    end
  end

  assign bus.state      = r_state;
  assign bus.stop       = r_stop;
  assign bus.game_over  = r_game_over;
  assign bus.blink      = r_blink;
  assign bus.high_score = r_high_score;

endmodule

// File: tb/tb_game_fsm.sv
// tb/tb_game_fsm.sv - scoreboard bench for game_fsm; covers GAME_FSM_LIVES_EN both ways.
module tb_game_fsm;
  logic clk = 1'b0;
  logic rst;

  game_fsm_if bus ();

  game_fsm #(.LIVES(3), .BOMB_COLOR(2'b11)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [1:0] st;
    logic [1:0] lv;
    logic       bl;
    logic [6:0] hs;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

`ifdef GAME_FSM_LIVES_EN
  localparam logic [1:0] LIVES_AFTER_G1 = 2'd0;
`else
  localparam logic [1:0] LIVES_AFTER_G1 = 2'd3;
`endif

  task automatic check(input string nm, input string fld, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check(mon_e.nm, "state",      int'(bus.state),      int'(mon_e.st));
      check(mon_e.nm, "stop",       int'(bus.stop),       int'(mon_e.st != 2'd1));
      check(mon_e.nm, "game_over",  int'(bus.game_over),  int'(mon_e.st == 2'd3));
      check(mon_e.nm, "lives",      int'(bus.lives),      int'(mon_e.lv));
      check(mon_e.nm, "blink",      int'(bus.blink),      int'(mon_e.bl));
      check(mon_e.nm, "high_score", int'(bus.high_score), int'(mon_e.hs));
    end
  end

  task automatic cyc(input string nm, input logic [1:0] s, input logic [1:0] l,
                     input logic b, input logic [6:0] h);
    exp_t e;
    e.nm = nm; e.st = s; e.lv = l; e.bl = b; e.hs = h;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.pause = 0; bus.left = 1; bus.right = 0; bus.one_hz = 0;
    bus.end_game = 0; bus.collision = 0; bus.fall_clr = 2'd0; bus.score = 7'd0;
    cyc("reset", 2'd0, 2'd3, 1'b0, 7'd0);
    rst = 1'b0;
    cyc("held_through_rst", 2'd0, 2'd3, 1'b0, 7'd0);
    bus.left = 0;
    cyc("idle_quiet", 2'd0, 2'd3, 1'b0, 7'd0);
    bus.right = 1;
    cyc("right_edge", 2'd1, 2'd3, 1'b0, 7'd0);
    cyc("right_hold1", 2'd1, 2'd3, 1'b0, 7'd0);
    cyc("right_hold2", 2'd1, 2'd3, 1'b0, 7'd0);
    bus.right = 0;
    cyc("right_drop", 2'd1, 2'd3, 1'b0, 7'd0);

    bus.pause = 1;
    cyc("pause_edge", 2'd2, 2'd3, 1'b0, 7'd0);
    for (int i = 0; i < 9; i++) cyc("pause_hold", 2'd2, 2'd3, 1'b0, 7'd0);
    bus.pause = 0;
    cyc("pause_drop", 2'd2, 2'd3, 1'b0, 7'd0);
    bus.pause = 1;
    cyc("resume", 2'd1, 2'd3, 1'b0, 7'd0);
    bus.pause = 0;
    cyc("resume_drop", 2'd1, 2'd3, 1'b0, 7'd0);

    bus.pause = 1;
    cyc("pause2", 2'd2, 2'd3, 1'b0, 7'd0);
    bus.pause = 0;
    cyc("pause2_drop", 2'd2, 2'd3, 1'b0, 7'd0);
    for (int i = 0; i < 10; i++) begin
      bus.one_hz = (i % 2 == 0);
      cyc("blink_pause", 2'd2, 2'd3, logic'(((i / 2) + 1) % 2), 7'd0);
    end
    bus.one_hz = 0;
    bus.pause = 1;
    cyc("blink_clear", 2'd1, 2'd3, 1'b0, 7'd0);
    bus.pause = 0;
    cyc("play_again", 2'd1, 2'd3, 1'b0, 7'd0);

`ifdef GAME_FSM_LIVES_EN
    bus.collision = 1; bus.fall_clr = 2'd1;
    cyc("safe_item", 2'd1, 2'd3, 1'b0, 7'd0);
    bus.collision = 0;
    cyc("no_coll", 2'd1, 2'd3, 1'b0, 7'd0);
    bus.collision = 1; bus.fall_clr = 2'd3;
    cyc("bomb1", 2'd1, 2'd2, 1'b0, 7'd0);
    bus.collision = 0;
    cyc("after_bomb1", 2'd1, 2'd2, 1'b0, 7'd0);
    bus.collision = 1;
    cyc("bomb2", 2'd1, 2'd1, 1'b0, 7'd0);
    bus.collision = 0;
    cyc("after_bomb2", 2'd1, 2'd1, 1'b0, 7'd0);
    bus.collision = 1; bus.score = 7'd42;
    cyc("bomb3_over", 2'd3, 2'd0, 1'b0, 7'd42);
    bus.collision = 0;
`else
    bus.fall_clr = 2'd3;
    for (int i = 0; i < 5; i++) begin
      bus.collision = 1;
      cyc("bomb_ignored", 2'd1, 2'd3, 1'b0, 7'd0);
    end
    bus.collision = 0;
    bus.score = 7'd42; bus.end_game = 1;
    cyc("end_game_over", 2'd3, 2'd3, 1'b0, 7'd42);
    bus.end_game = 0;
`endif

    bus.pause = 1; bus.right = 1;
    cyc("over_terminal", 2'd3, LIVES_AFTER_G1, 1'b0, 7'd42);
    bus.pause = 0; bus.right = 0;
    cyc("over_hold", 2'd3, LIVES_AFTER_G1, 1'b0, 7'd42);
    bus.one_hz = 1;
    cyc("over_blink", 2'd3, LIVES_AFTER_G1, 1'b1, 7'd42);
    bus.one_hz = 0;
    cyc("over_blink_hold", 2'd3, LIVES_AFTER_G1, 1'b1, 7'd42);

    rst = 1;
    cyc("rst_from_over", 2'd0, 2'd3, 1'b0, 7'd42);
    rst = 0;
    cyc("idle_g2", 2'd0, 2'd3, 1'b0, 7'd42);
    bus.right = 1;
    cyc("start_g2", 2'd1, 2'd3, 1'b0, 7'd42);
    bus.right = 0; bus.score = 7'd17;
    cyc("play_g2", 2'd1, 2'd3, 1'b0, 7'd42);
    bus.pause = 1;
    cyc("pause_g2", 2'd2, 2'd3, 1'b0, 7'd42);
    bus.pause = 0;
    cyc("pause_g2_drop", 2'd2, 2'd3, 1'b0, 7'd42);
    rst = 1; bus.pause = 1;
    cyc("rst_mid_pause", 2'd0, 2'd3, 1'b0, 7'd42);
    rst = 0;
    cyc("pause_held_rst", 2'd0, 2'd3, 1'b0, 7'd42);
    bus.pause = 0;
    cyc("idle_g3", 2'd0, 2'd3, 1'b0, 7'd42);
    bus.pause = 1; bus.right = 1;
    cyc("idle_pause_right", 2'd1, 2'd3, 1'b0, 7'd42);
    bus.pause = 0; bus.right = 0;
    cyc("pause_discarded", 2'd1, 2'd3, 1'b0, 7'd42);
    bus.pause = 1; bus.end_game = 1;
    cyc("prio_over", 2'd3, 2'd3, 1'b0, 7'd42);
    bus.pause = 0; bus.end_game = 0;
    cyc("over_g3", 2'd3, 2'd3, 1'b0, 7'd42);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
